// File: rtl/ariane_axi.sv
// Ariane AXI channel and bundle types as seen by the cache subsystem's master port.
// Contents: channel structs (aw/w/b/ar/r) and the req_t/resp_t bundles.
// The ID is 4 bits wide, which is the width the traffic-class decode expects.
package ariane_axi;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned UserWidth = 1;

  typedef logic [IdWidth-1:0]     id_t;
  typedef logic [AddrWidth-1:0]   addr_t;
  typedef logic [DataWidth-1:0]   data_t;
  typedef logic [DataWidth/8-1:0] strb_t;
  typedef logic [UserWidth-1:0]   user_t;

  typedef struct packed {
    id_t         id;
    addr_t       addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    user_t       user;
  } aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } b_chan_t;

  typedef struct packed {
    id_t         id;
    addr_t       addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    user_t       user;
  } ar_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     r_valid;
    r_chan_t  r;
  } resp_t;

endpackage

// File: rtl/std_cache_pkg.sv
// Cache subsystem shared definitions used by the AXI outstanding limiter.
// Contents: traffic-class enum, decoded-class struct, AXI ID -> class decode.
//   I$ = 4'b0000, bypass = 4'b10xx, D$ = 4'b1100; anything else is
//   reported as unknown and accounted as I$.
package std_cache_pkg;

  typedef enum logic [1:0] {
    CLS_ICACHE = 2'd0,
    CLS_BYPASS = 2'd1,
    CLS_DCACHE = 2'd2
  } axi_cls_e;

  localparam int unsigned NumCls = 3;

  typedef struct packed {
    axi_cls_e cls;
    logic     unknown;
  } axi_cls_dec_t;

  function automatic axi_cls_dec_t axi_id_to_cls(input logic [3:0] id);
    axi_cls_dec_t dec;
    dec.cls     = CLS_ICACHE;
    dec.unknown = 1'b0;
    if (id == 4'b0000) begin
      dec.cls = CLS_ICACHE;
    end else if (id[3:2] == 2'b10) begin
      dec.cls = CLS_BYPASS;
    end else if (id == 4'b1100) begin
      dec.cls = CLS_DCACHE;
    end else begin
      dec.unknown = 1'b1;
    end
    return dec;
  endfunction

endpackage

// File: rtl/axi_txn_counter.sv
// Outstanding-transaction counter for one traffic class on one direction.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   inc_i         transaction issued (address handshake)
//   dec_i         transaction completed (R-last / B handshake)
//   cnt_o         registered count
//   at_max_o      registered count has reached MAX (gate closed)
//   underflow_o   combinational pulse: decrement requested at zero
// Simultaneous inc/dec leaves the count unchanged; decrement at zero saturates.
module axi_txn_counter #(
  parameter int unsigned MAX  = 4,
  parameter int unsigned CntW = $clog2(MAX) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] cnt_o,
  output logic            at_max_o,
  output logic            underflow_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    if (inc_i && !dec_i) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) begin
        underflow_o = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o    = cnt_q;
  assign at_max_o = (cnt_q >= CntW'(MAX));

  // The issue gate keeps a class from incrementing once it sits at MAX.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(inc_i && !dec_i && at_max_o));

endmodule

// File: rtl/axi_outstanding_limiter.sv
// Per-traffic-class outstanding-transaction limiter on the cache subsystem's
// AXI master port. Gates AR/AW per class, supports draining, reports idle and
// sticky protocol errors. All other fields pass straight through.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   drain_i       stop issuing new AR/AW; in-flight traffic completes
//   slv_req_i     request from the cache subsystem
//   slv_resp_o    response to the cache subsystem
//   mst_req_o     request to the interconnect
//   mst_resp_i    response from the interconnect
//   idle_o        all counters zero and no AR/AW held
//   rd_cnt_o      outstanding reads  [2]=D$ [1]=bypass [0]=I$
//   wr_cnt_o      outstanding writes, same indexing
//   err_o         sticky: counter underflow or unknown ID handshaked
module axi_outstanding_limiter
  import std_cache_pkg::*;
#(
  parameter int unsigned MaxRd = 4,
  parameter int unsigned MaxWr = 4,
  parameter int unsigned CntW  = $clog2((MaxRd > MaxWr) ? MaxRd : MaxWr) + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          drain_i,
  input  ariane_axi::req_t              slv_req_i,
  output ariane_axi::resp_t             slv_resp_o,
  output ariane_axi::req_t              mst_req_o,
  input  ariane_axi::resp_t             mst_resp_i,
  output logic                          idle_o,
  output logic [NumCls-1:0][CntW-1:0]   rd_cnt_o,
  output logic [NumCls-1:0][CntW-1:0]   wr_cnt_o,
  output logic                          err_o
);

  axi_cls_dec_t ar_dec, aw_dec, r_dec, b_dec;

  logic ar_hold_q, ar_hold_d;
  logic aw_hold_q, aw_hold_d;
  logic err_q, err_d;

  logic ar_open, aw_open;
  logic ar_valid_gated, aw_valid_gated;
  logic ar_hs, aw_hs, r_last_hs, b_hs;

  logic [NumCls-1:0] rd_inc, rd_dec, rd_at_max, rd_unf;
  logic [NumCls-1:0] wr_inc, wr_dec, wr_at_max, wr_unf;

  always_comb begin
    ar_dec = axi_id_to_cls(slv_req_i.ar.id);
    aw_dec = axi_id_to_cls(slv_req_i.aw.id);
    r_dec  = axi_id_to_cls(mst_resp_i.r.id);
    b_dec  = axi_id_to_cls(mst_resp_i.b.id);

    // Limit uses the registered count only, so no R/B -> AR/AW comb path.
    // A held request keeps the gate open regardless of drain/limit so that
    // a presented valid is never withdrawn before its handshake.
    ar_open = ar_hold_q | (!drain_i & !rd_at_max[ar_dec.cls]);
    aw_open = aw_hold_q | (!drain_i & !wr_at_max[aw_dec.cls]);

    ar_valid_gated = slv_req_i.ar_valid & ar_open & !rst_i;
    aw_valid_gated = slv_req_i.aw_valid & aw_open & !rst_i;

    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = ar_valid_gated;
    mst_req_o.aw_valid = aw_valid_gated;

    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_open & !rst_i;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_open & !rst_i;

    ar_hs     = ar_valid_gated & mst_resp_i.ar_ready;
    aw_hs     = aw_valid_gated & mst_resp_i.aw_ready;
    r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
    b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;

    rd_inc = '0;
    rd_dec = '0;
    wr_inc = '0;
    wr_dec = '0;
    if (ar_hs)     rd_inc[ar_dec.cls] = 1'b1;
    if (r_last_hs) rd_dec[r_dec.cls]  = 1'b1;
    if (aw_hs)     wr_inc[aw_dec.cls] = 1'b1;
    if (b_hs)      wr_dec[b_dec.cls]  = 1'b1;

    ar_hold_d = ar_hold_q;
    if (ar_hs) begin
      ar_hold_d = 1'b0;
    end else if (ar_valid_gated) begin
      ar_hold_d = 1'b1;
    end

    aw_hold_d = aw_hold_q;
    if (aw_hs) begin
      aw_hold_d = 1'b0;
    end else if (aw_valid_gated) begin
      aw_hold_d = 1'b1;
    end

    err_d = err_q
          | (|rd_unf) | (|wr_unf)
          | (ar_hs & ar_dec.unknown)
          | (aw_hs & aw_dec.unknown)
          | (r_last_hs & r_dec.unknown)
          | (b_hs & b_dec.unknown);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ar_hold_q <= 1'b0;
      aw_hold_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ar_hold_q <= ar_hold_d;
      aw_hold_q <= aw_hold_d;
      err_q     <= err_d;
    end
  end

  for (genvar c = 0; c < NumCls; c++) begin : g_cls
    axi_txn_counter #(
      .MAX  (MaxRd),
      .CntW (CntW)
    ) i_rd_cnt (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .inc_i       (rd_inc[c]),
      .dec_i       (rd_dec[c]),
      .cnt_o       (rd_cnt_o[c]),
      .at_max_o    (rd_at_max[c]),
      .underflow_o (rd_unf[c])
    );

    axi_txn_counter #(
      .MAX  (MaxWr),
      .CntW (CntW)
    ) i_wr_cnt (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .inc_i       (wr_inc[c]),
      .dec_i       (wr_dec[c]),
      .cnt_o       (wr_cnt_o[c]),
      .at_max_o    (wr_at_max[c]),
      .underflow_o (wr_unf[c])
    );
  end

  assign idle_o = (rd_cnt_o == '0) && (wr_cnt_o == '0) && !ar_hold_q && !aw_hold_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_axi_outstanding_limiter.sv
// Self-checking bench for axi_outstanding_limiter: address handshakes seen on
// the interconnect side are matched against a queue of expected {id, addr}.
module tb_axi_outstanding_limiter;
  import ariane_axi::*;

  localparam int unsigned CntW = 3;
  localparam logic [3:0] ID_D  = 4'b1100;
  localparam logic [3:0] ID_I  = 4'b0000;
  localparam logic [3:0] ID_BA = 4'b1010;
  localparam logic [3:0] ID_BB = 4'b1001;
  localparam logic [3:0] ID_X  = 4'b0110;

  typedef logic [67:0] val_t;

  logic clk = 1'b0;
  logic rst;
  logic drain;
  req_t  slv_req, mst_req;
  resp_t slv_resp, mst_resp;
  logic idle, err;
  logic [2:0][CntW-1:0] rd_cnt, wr_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  val_t ar_q[$];
  val_t aw_q[$];

  always #5 clk = ~clk;

  axi_outstanding_limiter #(
    .MaxRd (4),
    .MaxWr (4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .drain_i    (drain),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp),
    .idle_o     (idle),
    .rd_cnt_o   (rd_cnt),
    .wr_cnt_o   (wr_cnt),
    .err_o      (err)
  );

  task automatic check(input string tag, input val_t got, input val_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic val_t tr(input logic [3:0] id, input logic [63:0] addr);
    return {id, addr};
  endfunction

  // Scoreboard side: every address handshake on the interconnect must match
  // the oldest expectation pushed by the stimulus.
  always @(negedge clk) begin
    if (mst_req.ar_valid && mst_resp.ar_ready) begin
      check("ar_expected", val_t'(ar_q.size() != 0), val_t'(1));
      if (ar_q.size() != 0) check("ar_txn", tr(mst_req.ar.id, mst_req.ar.addr), ar_q.pop_front());
    end
    if (mst_req.aw_valid && mst_resp.aw_ready) begin
      check("aw_expected", val_t'(aw_q.size() != 0), val_t'(1));
      if (aw_q.size() != 0) check("aw_txn", tr(mst_req.aw.id, mst_req.aw.addr), aw_q.pop_front());
    end
  end

  initial begin
    slv_req  = '0;
    mst_resp = '0;
    drain    = 1'b0;
    rst      = 1'b1;
    // Requests presented during reset must not leak through.
    slv_req.ar_valid    = 1'b1;
    slv_req.ar.id       = ID_D;
    slv_req.aw_valid    = 1'b1;
    slv_req.aw.id       = ID_D;
    mst_resp.ar_ready   = 1'b1;
    mst_resp.aw_ready   = 1'b1;
    repeat (2) @(posedge clk);
    smp();
    check("rst_mst_ar_valid", val_t'(mst_req.ar_valid), val_t'(0));
    check("rst_mst_aw_valid", val_t'(mst_req.aw_valid), val_t'(0));
    check("rst_slv_ar_ready", val_t'(slv_resp.ar_ready), val_t'(0));
    check("rst_slv_aw_ready", val_t'(slv_resp.aw_ready), val_t'(0));
    check("rst_idle", val_t'(idle), val_t'(1));
    check("rst_err", val_t'(err), val_t'(0));
    check("rst_rd_cnt", val_t'(rd_cnt), val_t'(0));
    check("rst_wr_cnt", val_t'(wr_cnt), val_t'(0));
    check("rst_passthru_id", val_t'(mst_req.ar.id), val_t'(ID_D));

    cyc();
    rst = 1'b0;
    slv_req.ar_valid  = 1'b0;
    slv_req.aw_valid  = 1'b0;
    slv_req.r_ready   = 1'b1;
    slv_req.b_ready   = 1'b1;

    // 1: five back-to-back D$ reads, the fifth hits the limit.
    for (int k = 0; k < 5; k++) begin
      cyc();
      slv_req.ar_valid = 1'b1;
      slv_req.ar.id    = ID_D;
      slv_req.ar.addr  = 64'(k);
      if (k < 4) ar_q.push_back(tr(ID_D, 64'(k)));
      smp();
      check("t1_slv_ar_ready", val_t'(slv_resp.ar_ready), val_t'(k < 4));
    end
    cyc();
    smp();
    check("t1_rd_cnt_d", val_t'(rd_cnt[2]), val_t'(4));
    check("t1_mst_ar_valid_blocked", val_t'(mst_req.ar_valid), val_t'(0));

    // 2: one R-last frees a slot, gate opens only a cycle later.
    cyc();
    mst_resp.r_valid = 1'b1;
    mst_resp.r.id    = ID_D;
    mst_resp.r.last  = 1'b1;
    smp();
    check("t2_ready_same_cycle", val_t'(slv_resp.ar_ready), val_t'(0));
    cyc();
    mst_resp.r_valid = 1'b0;
    ar_q.push_back(tr(ID_D, 64'd4));
    smp();
    check("t2_rd_cnt_d_dec", val_t'(rd_cnt[2]), val_t'(3));
    check("t2_ready_next_cycle", val_t'(slv_resp.ar_ready), val_t'(1));
    cyc();
    slv_req.ar_valid = 1'b0;
    smp();
    check("t2_rd_cnt_d_full", val_t'(rd_cnt[2]), val_t'(4));

    // 3: other classes are unaffected by the D$ limit.
    cyc();
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = ID_I;
    slv_req.ar.addr  = 64'h10;
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = ID_BA;
    slv_req.aw.addr  = 64'h20;
    ar_q.push_back(tr(ID_I, 64'h10));
    aw_q.push_back(tr(ID_BA, 64'h20));
    smp();
    check("t3_i_ar_ready", val_t'(slv_resp.ar_ready), val_t'(1));
    check("t3_byp_aw_ready", val_t'(slv_resp.aw_ready), val_t'(1));
    cyc();
    slv_req.aw_valid = 1'b0;
    slv_req.ar.id    = ID_D;
    slv_req.ar.addr  = 64'h11;
    smp();
    check("t3_rd_cnt_i", val_t'(rd_cnt[0]), val_t'(1));
    check("t3_rd_cnt_d", val_t'(rd_cnt[2]), val_t'(4));
    check("t3_wr_cnt_byp", val_t'(wr_cnt[1]), val_t'(1));
    check("t3_d_still_blocked", val_t'(slv_resp.ar_ready), val_t'(0));
    cyc();
    slv_req.ar.id   = ID_BB;
    slv_req.ar.addr = 64'h12;
    ar_q.push_back(tr(ID_BB, 64'h12));
    smp();
    check("t3_byp_ar_ready", val_t'(slv_resp.ar_ready), val_t'(1));
    cyc();
    slv_req.ar_valid = 1'b0;
    smp();
    check("t3_rd_cnt_byp", val_t'(rd_cnt[1]), val_t'(1));

    // Non-last beat must not retire a read.
    cyc();
    mst_resp.r_valid = 1'b1;
    mst_resp.r.id    = ID_D;
    mst_resp.r.last  = 1'b0;
    cyc();
    mst_resp.r_valid = 1'b0;
    smp();
    check("t3_nonlast_no_dec", val_t'(rd_cnt[2]), val_t'(4));

    // Retire everything outstanding.
    for (int k = 0; k < 6; k++) begin
      cyc();
      mst_resp.r_valid = 1'b1;
      mst_resp.r.last  = 1'b1;
      mst_resp.r.id    = (k < 4) ? ID_D : ((k == 4) ? ID_I : ID_BB);
    end
    cyc();
    mst_resp.r_valid = 1'b0;
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = ID_BA;
    cyc();
    mst_resp.b_valid = 1'b0;
    smp();
    check("t3_rd_all_zero", val_t'(rd_cnt), val_t'(0));
    check("t3_wr_all_zero", val_t'(wr_cnt), val_t'(0));
    check("t3_idle", val_t'(idle), val_t'(1));
    check("t3_no_err", val_t'(err), val_t'(0));

    // 4: a presented AR survives drain until its handshake.
    cyc();
    mst_resp.ar_ready = 1'b0;
    slv_req.ar_valid  = 1'b1;
    slv_req.ar.id     = ID_D;
    slv_req.ar.addr   = 64'h30;
    ar_q.push_back(tr(ID_D, 64'h30));
    smp();
    check("t4_valid_presented", val_t'(mst_req.ar_valid), val_t'(1));
    cyc();
    drain = 1'b1;
    smp();
    check("t4_valid_held_drain", val_t'(mst_req.ar_valid), val_t'(1));
    check("t4_not_idle_held", val_t'(idle), val_t'(0));
    cyc();
    mst_resp.ar_ready = 1'b1;
    smp();
    check("t4_held_hs", val_t'(slv_resp.ar_ready), val_t'(1));
    cyc();
    slv_req.ar.addr = 64'h31;
    smp();
    check("t4_drain_blocks_valid", val_t'(mst_req.ar_valid), val_t'(0));
    check("t4_drain_blocks_ready", val_t'(slv_resp.ar_ready), val_t'(0));
    check("t4_rd_cnt_d", val_t'(rd_cnt[2]), val_t'(1));
    cyc();
    slv_req.ar_valid = 1'b0;
    mst_resp.r_valid = 1'b1;
    mst_resp.r.id    = ID_D;
    mst_resp.r.last  = 1'b1;
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = ID_D;
    slv_req.aw.addr  = 64'h40;
    smp();
    check("t4_not_idle_last_r", val_t'(idle), val_t'(0));
    check("t4_drain_blocks_aw", val_t'(mst_req.aw_valid), val_t'(0));
    cyc();
    mst_resp.r_valid = 1'b0;
    slv_req.aw_valid = 1'b0;
    smp();
    check("t4_idle_after_r", val_t'(idle), val_t'(1));
    drain = 1'b0;

    // 5: B at zero count -> saturate, sticky error until reset.
    cyc();
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = ID_D;
    cyc();
    mst_resp.b_valid = 1'b0;
    smp();
    check("t5_wr_cnt_sat", val_t'(wr_cnt[2]), val_t'(0));
    check("t5_err_set", val_t'(err), val_t'(1));
    repeat (3) cyc();
    smp();
    check("t5_err_sticky", val_t'(err), val_t'(1));
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    smp();
    check("t5_err_cleared", val_t'(err), val_t'(0));

    // 6: same-cycle inc/dec, write limit, unknown ID.
    for (int k = 0; k < 2; k++) begin
      cyc();
      slv_req.aw_valid = 1'b1;
      slv_req.aw.id    = ID_D;
      slv_req.aw.addr  = 64'h50 + 64'(k);
      aw_q.push_back(tr(ID_D, 64'h50 + 64'(k)));
    end
    cyc();
    slv_req.aw_valid = 1'b0;
    smp();
    check("t6_wr_cnt_2", val_t'(wr_cnt[2]), val_t'(2));
    cyc();
    slv_req.aw_valid = 1'b1;
    slv_req.aw.addr  = 64'h52;
    aw_q.push_back(tr(ID_D, 64'h52));
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = ID_D;
    cyc();
    slv_req.aw_valid = 1'b0;
    mst_resp.b_valid = 1'b0;
    smp();
    check("t6_inc_dec_same", val_t'(wr_cnt[2]), val_t'(2));
    check("t6_no_err", val_t'(err), val_t'(0));
    for (int k = 0; k < 3; k++) begin
      cyc();
      slv_req.aw_valid = 1'b1;
      slv_req.aw.addr  = 64'h60 + 64'(k);
      if (k < 2) aw_q.push_back(tr(ID_D, 64'h60 + 64'(k)));
      smp();
      check("t6_wr_limit_ready", val_t'(slv_resp.aw_ready), val_t'(k < 2));
    end
    cyc();
    slv_req.aw_valid = 1'b0;
    smp();
    check("t6_wr_cnt_max", val_t'(wr_cnt[2]), val_t'(4));
    cyc();
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = ID_X;
    slv_req.ar.addr  = 64'h70;
    ar_q.push_back(tr(ID_X, 64'h70));
    smp();
    check("t6_err_not_yet", val_t'(err), val_t'(0));
    cyc();
    slv_req.ar_valid = 1'b0;
    smp();
    check("t6_unknown_as_i", val_t'(rd_cnt[0]), val_t'(1));
    check("t6_unknown_err", val_t'(err), val_t'(1));

    check("ar_q_drained", val_t'(ar_q.size()), val_t'(0));
    check("aw_q_drained", val_t'(aw_q.size()), val_t'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
